// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
package fetch_ctrl_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StMemWait,
    StFault
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: a load in EX whose destination feeds the instruction in ID.
module hazard_detect
  import fetch_ctrl_pkg::*;
(
  input  logic                  mem_read_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  output logic                  hazard_o
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hazard_o = mem_read_i && (rd_i != '0) && ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/fetch_control.sv
// IF-stage sequencer: arbitrates branch redirects, load-use stalls and imem wait states.
module fetch_control
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = fetch_ctrl_pkg::XLEN,
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  branch_taken,
  input  logic [XLEN-1:0]       branch_target,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  imem_ready,
  output logic                  load_pc,
  output logic                  mux_sel,
  output logic [XLEN-1:0]       pc_branch_value,
  output logic                  load_if_id_register,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  fault,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int unsigned BootW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  // With no boot delay the controller leaves reset straight into RUN.
  localparam state_e ResetState = (BOOT_CYCLES == 0) ? StRun : StBoot;

  state_e           state_q, state_d;
  logic [BootW-1:0] boot_q, boot_d;
  logic             pend_q, pend_d;
  logic [XLEN-1:0]  tgt_q, tgt_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic            hazard;
  logic            misaligned;
  logic            ld_pc, sel, ld_ifid, flush, bubble;
  logic [XLEN-1:0] redir;

  hazard_detect u_hazard_detect (
    .mem_read_i (id_ex_mem_read),
    .rd_i       (id_ex_rd),
    .rs1_i      (if_id_rs1),
    .rs2_i      (if_id_rs2),
    .hazard_o   (hazard)
  );

  assign misaligned = branch_taken && (branch_target[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    boot_d  = boot_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
    fault_d = fault_q;
    ld_pc   = 1'b0;
    sel     = 1'b0;
    ld_ifid = 1'b0;
    flush   = 1'b0;
    bubble  = 1'b0;
    redir   = '0;

    unique case (state_q)
      StBoot: begin
        if (32'(boot_q) == BOOT_CYCLES - 32'd1) begin
          state_d = StRun;
        end else begin
          boot_d = boot_q + 1'b1;
        end
      end
      StRun: begin
        if (misaligned) begin
          state_d = StFault;
          fault_d = 1'b1;
        end else if (branch_taken && imem_ready) begin
          ld_pc  = 1'b1;
          sel    = 1'b1;
          redir  = branch_target;
          flush  = 1'b1;
          bubble = 1'b1;
        end else if (branch_taken) begin
          tgt_d   = branch_target;
          pend_d  = 1'b1;
          state_d = StMemWait;
          bubble  = 1'b1;
        end else if (hazard) begin
          bubble = 1'b1;
        end else if (!imem_ready) begin
          state_d = StMemWait;
          bubble  = 1'b1;
        end else begin
          ld_pc   = 1'b1;
          ld_ifid = 1'b1;
        end
      end
      StMemWait: begin
        if (misaligned) begin
          state_d = StFault;
          fault_d = 1'b1;
          pend_d  = 1'b0;
        end else if (imem_ready) begin
          state_d = StRun;
          pend_d  = 1'b0;
          // A branch resolving in the same cycle supersedes the saved target.
          if (branch_taken || pend_q) begin
            ld_pc  = 1'b1;
            sel    = 1'b1;
            redir  = branch_taken ? branch_target : tgt_q;
            flush  = 1'b1;
            bubble = 1'b1;
          end else begin
            ld_pc   = 1'b1;
            ld_ifid = 1'b1;
          end
        end else begin
          bubble = 1'b1;
          if (branch_taken) begin
            tgt_d  = branch_target;
            pend_d = 1'b1;
          end
        end
      end
      StFault: ;
      default: state_d = ResetState;
    endcase

    stall_d = stall_q;
    if ((state_q == StRun || state_q == StMemWait) && !ld_pc && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ResetState;
      boot_q  <= '0;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
      fault_q <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      fault_q <= fault_d;
      stall_q <= stall_d;
    end
  end

  // Outputs are forced low while reset is held, even when reset lands directly in RUN.
  always_comb begin
    load_pc             = reset && ld_pc;
    mux_sel             = reset && sel;
    load_if_id_register = reset && ld_ifid;
    if_id_flush         = reset && flush;
    id_ex_bubble        = reset && bubble;
    pc_branch_value     = reset ? redir : '0;
  end

  assign fault        = fault_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_fetch_control.sv
// Directed self-checking bench for fetch_control.
module tb_fetch_control;

  logic        clock;
  logic        reset;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rd, if_id_rs1, if_id_rs2;
  logic        imem_ready;
  logic        load_pc, mux_sel, load_if_id_register, if_id_flush, id_ex_bubble, fault;
  logic [31:0] pc_branch_value;
  logic [15:0] stall_cycles;

  logic        s_ready;
  logic        s_load_pc, s_mux_sel, s_ld_ifid, s_flush, s_bubble, s_fault;
  logic [31:0] s_pcbv;
  logic [1:0]  s_stall;

  int n_checks = 0;
  int n_errors = 0;

  fetch_control #(.XLEN(32), .BOOT_CYCLES(2), .CNT_W(16)) dut (
    .clock               (clock),
    .reset               (reset),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .id_ex_mem_read      (id_ex_mem_read),
    .id_ex_rd            (id_ex_rd),
    .if_id_rs1           (if_id_rs1),
    .if_id_rs2           (if_id_rs2),
    .imem_ready          (imem_ready),
    .load_pc             (load_pc),
    .mux_sel             (mux_sel),
    .pc_branch_value     (pc_branch_value),
    .load_if_id_register (load_if_id_register),
    .if_id_flush         (if_id_flush),
    .id_ex_bubble        (id_ex_bubble),
    .fault               (fault),
    .stall_cycles        (stall_cycles)
  );

  // Zero boot delay and a 2-bit counter to reach saturation quickly.
  fetch_control #(.XLEN(32), .BOOT_CYCLES(0), .CNT_W(2)) dut_sat (
    .clock               (clock),
    .reset               (reset),
    .branch_taken        (1'b0),
    .branch_target       (32'h0),
    .id_ex_mem_read      (1'b0),
    .id_ex_rd            (5'd0),
    .if_id_rs1           (5'd0),
    .if_id_rs2           (5'd0),
    .imem_ready          (s_ready),
    .load_pc             (s_load_pc),
    .mux_sel             (s_mux_sel),
    .pc_branch_value     (s_pcbv),
    .load_if_id_register (s_ld_ifid),
    .if_id_flush         (s_flush),
    .id_ex_bubble        (s_bubble),
    .fault               (s_fault),
    .stall_cycles        (s_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset          = 1'b0;
    branch_taken   = 1'b0;
    branch_target  = '0;
    id_ex_mem_read = 1'b0;
    id_ex_rd       = '0;
    if_id_rs1      = '0;
    if_id_rs2      = '0;
    imem_ready     = 1'b1;
    s_ready        = 1'b1;

    repeat (3) @(negedge clock);
    check_eq("rst_load_pc", load_pc, 0);
    check_eq("rst_pcbv", pc_branch_value, 0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_stall", stall_cycles, 0);
    check_eq("rst_ctrl", {mux_sel, load_if_id_register, if_id_flush, id_ex_bubble}, 0);
    check_eq("rst_sat_load_pc", s_load_pc, 0);

    reset = 1'b1;
    #1;
    check_eq("boot1_load_pc", load_pc, 0);
    check_eq("boot0_sat_load_pc", s_load_pc, 1);
    step();
    check_eq("boot2_load_pc", load_pc, 0);
    step();
    check_eq("run_load_pc", load_pc, 1);
    check_eq("run_mux_sel", mux_sel, 0);
    check_eq("run_ld_ifid", load_if_id_register, 1);
    check_eq("run_stall", stall_cycles, 0);
    step();
    check_eq("run2_load_pc", load_pc, 1);

    // Taken branch with a simultaneous load-use hazard: branch wins.
    branch_taken = 1'b1; branch_target = 32'h10;
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_rs2 = 5'd5;
    #1;
    check_eq("br_ctrl", {mux_sel, load_pc, if_id_flush, id_ex_bubble, load_if_id_register}, 5'b11110);
    check_eq("br_pcbv", pc_branch_value, 32'h10);
    step();
    check_eq("br_no_stall", stall_cycles, 0);

    branch_taken = 1'b0;
    #1;
    check_eq("hz_ctrl", {load_pc, id_ex_bubble, load_if_id_register}, 3'b010);
    step();
    check_eq("hz_stall", stall_cycles, 1);
    id_ex_rd = 5'd0;
    #1;
    check_eq("hz_x0_load_pc", load_pc, 1);
    step();
    check_eq("hz_x0_stall", stall_cycles, 1);

    // Three wait-state cycles with a branch arriving in the second.
    id_ex_mem_read = 1'b0; if_id_rs2 = 5'd0; imem_ready = 1'b0;
    #1;
    check_eq("mw1_ctrl", {load_pc, load_if_id_register, id_ex_bubble}, 3'b001);
    step();
    branch_taken = 1'b1; branch_target = 32'h40;
    #1;
    check_eq("mw2_ctrl", {load_pc, load_if_id_register, if_id_flush}, 3'b000);
    step();
    branch_taken = 1'b0;
    #1;
    check_eq("mw3_ctrl", {load_pc, load_if_id_register, if_id_flush}, 3'b000);
    step();
    imem_ready = 1'b1;
    #1;
    check_eq("mw_redir_ctrl", {mux_sel, load_pc, if_id_flush}, 3'b111);
    check_eq("mw_redir_pcbv", pc_branch_value, 32'h40);
    step();
    check_eq("mw_stall", stall_cycles, 4);
    check_eq("mw_after_ctrl", {load_pc, mux_sel}, 2'b10);

    // Misaligned target traps and sticks.
    branch_taken = 1'b1; branch_target = 32'h22;
    #1;
    check_eq("flt_entry_ctrl", {load_pc, if_id_flush, load_if_id_register}, 3'b000);
    step();
    branch_taken = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("flt_fault", fault, 1);
      check_eq("flt_ctrl", {load_pc, load_if_id_register, if_id_flush, id_ex_bubble}, 0);
      step();
    end
    check_eq("flt_stall_frozen", stall_cycles, 5);
    reset = 1'b0;
    #1;
    check_eq("flt_rst_fault", fault, 0);
    check_eq("flt_rst_stall", stall_cycles, 0);
    step();
    reset = 1'b1;

    // Saturation on the narrow counter.
    step();
    s_ready = 1'b0;
    step();
    check_eq("sat_1", s_stall, 1);
    step();
    check_eq("sat_2", s_stall, 2);
    step();
    check_eq("sat_3", s_stall, 3);
    step();
    step();
    check_eq("sat_hold", s_stall, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_control.md
# fetch_control

Sequencing controller for the IF stage of the five-stage RISC-V pipeline. Drives the fetch unit's `load_pc`, `mux_sel`, `pc_branch_value` and `load_if_id_register` inputs, and the IF/ID flush and ID/EX bubble controls. Arbitrates taken-branch redirects, load-use stalls and instruction-memory wait states. Adds a post-reset boot delay, a sticky misaligned-target fault and a stall-cycle counter.

## Interface
- `XLEN`, 32, data/PC width
- `BOOT_CYCLES`, 2, idle cycles after reset release before the first fetch (0 allowed)
- `CNT_W`, 16, stall counter width

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low (0 = reset asserted)
- `branch_taken`  in  1  EX resolved a taken branch/jump this cycle
- `branch_target`  in  XLEN  target address, valid with `branch_taken`
- `id_ex_mem_read`  in  1  instruction in EX is a load
- `id_ex_rd`  in  5  its destination register
- `if_id_rs1`, `if_id_rs2`  in  5 each  source registers of the instruction in ID
- `imem_ready`  in  1  instruction memory delivers a valid word this cycle
- `load_pc`  out  1  PC write enable
- `mux_sel`  out  1  1 = PC takes `pc_branch_value`, 0 = PC+4
- `pc_branch_value`  out  XLEN  redirect address
- `load_if_id_register`  out  1  IF/ID write enable
- `if_id_flush`  out  1  clear IF/ID to NOP on this edge
- `id_ex_bubble`  out  1  insert NOP into ID/EX on this edge
- `fault`  out  1  sticky misaligned-target fault
- `stall_cycles`  out  CNT_W  saturating count of non-advancing cycles

## Operation
- States: BOOT, RUN, MEMWAIT, FAULT. Reset enters BOOT.
- Control outputs are combinational from state, registers and inputs. `stall_cycles`, `fault`, the pending flag and the saved target are registered.
- **BOOT**
  - All enables are 0; a counter runs to `BOOT_CYCLES`, then the FSM moves to RUN.
  - With `BOOT_CYCLES`=0, the first cycle after reset release is already RUN.
  - `branch_taken` is ignored in BOOT.
- **RUN**: the first matching rule applies.
  1. `branch_taken` with `branch_target[1:0]`≠0 -> next state FAULT. All enables 0.
  2. `branch_taken` with `imem_ready`=1 -> `mux_sel`=1, `pc_branch_value`=`branch_target`, `load_pc`=1, `if_id_flush`=1, `id_ex_bubble`=1, `load_if_id_register`=0.
  3. `branch_taken` with `imem_ready`=0 -> save the target, set pending, go to MEMWAIT. Enables 0, `id_ex_bubble`=1.
  4. Load-use hazard: `id_ex_mem_read` and `id_ex_rd`≠0 and `id_ex_rd` equals `if_id_rs1` or `if_id_rs2`. Response: `load_pc`=0, `load_if_id_register`=0, `id_ex_bubble`=1. Stay in RUN.
  5. `imem_ready`=0 -> go to MEMWAIT. Enables 0, `id_ex_bubble`=1.
  6. Otherwise `load_pc`=1, `load_if_id_register`=1, `mux_sel`=0.
- **MEMWAIT**
  - While `imem_ready`=0: enables 0, `id_ex_bubble`=1.
  - A `branch_taken` arriving here is validated (misaligned -> FAULT) and saved to pending. The last one wins.
  - When `imem_ready`=1 with pending set: perform a rule-2 redirect using the saved target, clear pending, go to RUN.
  - When `imem_ready`=1 without pending: perform a rule-6 advance, go to RUN.
  - The hazard check is ignored in MEMWAIT because ID/EX already holds a bubble.
- **FAULT**: all enables 0, `fault`=1. Exit only through reset.
- `stall_cycles` increments on every RUN or MEMWAIT cycle with `load_pc`=0. It saturates at all-ones. It does not count in BOOT or FAULT.

## Timing
- Reset values: state BOOT, pending 0, saved target 0, `fault`=0, `stall_cycles`=0. Every control output is 0 and `pc_branch_value`=0.
- Asserting reset mid-operation drops all outputs to 0 immediately (asynchronously) and clears pending.
- Zero-latency (combinational) response to `branch_taken`, hazard and `imem_ready`.
- A branch redirect costs 2 flushed instructions and 0 extra cycles.
- A load-use hazard costs exactly 1 stall cycle.
- Branch and hazard in the same cycle: the branch wins and no stall is taken.

## Structure
- Package `fetch_ctrl_pkg`: state enum (BOOT, RUN, MEMWAIT, FAULT), `XLEN`, `REG_ADDR_W`=5, `NOP_INSN`=32'h00000013.
- Sub-module `hazard_detect`: combinational load-use comparator producing a 1-bit `hazard`.

## Test plan
- Reset low 3 cycles, then high with `BOOT_CYCLES`=2 and `imem_ready`=1 -> `load_pc`=0 for 2 cycles, then 1 every cycle with `mux_sel`=0 and `stall_cycles`=0.
- In RUN, `branch_taken`=1, `branch_target`=32'h10 -> same cycle `mux_sel`=1, `pc_branch_value`=32'h10, `load_pc`=1, `if_id_flush`=1, `id_ex_bubble`=1.
- `id_ex_mem_read`=1, `id_ex_rd`=5, `if_id_rs2`=5 for one cycle -> `load_pc`=0, `id_ex_bubble`=1, `stall_cycles`=1. Repeat with `id_ex_rd`=0 -> no stall.
- `imem_ready`=0 for 3 cycles with `branch_taken`, target 32'h40, in the 2nd cycle -> 3 cycles with no enables. On `imem_ready`=1: redirect to 32'h40 with flush. `stall_cycles`=3.
- `branch_taken` with target 32'h22 -> `fault`=1, all enables 0 for 10 cycles. Reset clears `fault`.
- Force `stall_cycles` to 16'hFFFE, then 3 stall cycles -> value holds at 16'hFFFF.
